// File: rtl/f_branch_predict.sv
// f_branch_predict
//   Fetch-stage PC generator. Holds the fetch PC and predicts the next PC
//   with a direct-mapped branch target buffer (BTB) whose entries carry a
//   2-bit saturating direction counter. The execute stage's resolution
//   redirects fetch on a misprediction and trains the BTB for control
//   instructions.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   stall           hold the fetch PC this cycle (a redirect still wins)
//   e_valid         execute stage holds a valid resolved instruction
//   e_is_ctrl       that instruction is branch/jal/jalr
//   e_taken         resolved taken
//   e_pc            PC of the resolved instruction (BTB training index/tag)
//   e_jumppc        resolved target, written into the BTB
//   e_nextpc        architecturally correct next PC (redirect value)
//   e_fail_predict  misprediction flag from execute
//   pc              current fetch PC (registered)
//   pc_predicted    predicted next PC for the instruction at pc
//   pred_taken      prediction used the BTB target
module f_branch_predict #(
  parameter int              PC_W     = 13,
  parameter int              IDX_W    = 6,
  parameter logic [PC_W-1:0] RESET_PC = 13'h0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            e_valid,
  input  logic            e_is_ctrl,
  input  logic            e_taken,
  input  logic [PC_W-1:0] e_pc,
  input  logic [PC_W-1:0] e_jumppc,
  input  logic [PC_W-1:0] e_nextpc,
  input  logic            e_fail_predict,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_predicted,
  output logic            pred_taken
);

  localparam int         TAG_W     = PC_W - IDX_W;
  localparam int         DEPTH     = 2 ** IDX_W;
  localparam logic [1:0] CTR_RESET = 2'b01;  // weakly not-taken
  localparam logic [1:0] CTR_ALLOC = 2'b10;  // weakly taken

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    if (c == 2'b11) ctr_inc = 2'b11;
    else            ctr_inc = c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    if (c == 2'b00) ctr_dec = 2'b00;
    else            ctr_dec = c - 2'b01;
  endfunction

  logic             valid_r  [DEPTH];
  logic [TAG_W-1:0] tag_r    [DEPTH];
  logic [PC_W-1:0]  target_r [DEPTH];
  logic [1:0]       ctr_r    [DEPTH];
  logic [PC_W-1:0]  pc_r;

  logic [IDX_W-1:0] idx_s;
  logic [TAG_W-1:0] tag_s;
  logic             hit_s;
  logic             pred_taken_s;
  logic [PC_W-1:0]  pred_pc_s;

  logic [IDX_W-1:0] e_idx_s;
  logic [TAG_W-1:0] e_tag_s;
  logic             e_hit_s;
  logic             wr_en_s;
  logic [TAG_W-1:0] wr_tag_s;
  logic [PC_W-1:0]  wr_target_s;
  logic [1:0]       wr_ctr_s;
  logic             redirect_s;

  // Lookup for the current fetch PC; reads the pre-update array contents.
  always_comb begin
    idx_s        = pc_r[IDX_W-1:0];
    tag_s        = pc_r[PC_W-1:IDX_W];
    hit_s        = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
    pred_taken_s = hit_s && ctr_r[idx_s][1];
    if (pred_taken_s) pred_pc_s = target_r[idx_s];
    else              pred_pc_s = pc_r + PC_W'(1);  // wraps modulo 2^PC_W
  end

  // Training decision for the resolved control instruction.
  always_comb begin
    e_idx_s     = e_pc[IDX_W-1:0];
    e_tag_s     = e_pc[PC_W-1:IDX_W];
    e_hit_s     = valid_r[e_idx_s] && (tag_r[e_idx_s] == e_tag_s);
    wr_en_s     = 1'b0;
    wr_tag_s    = e_tag_s;
    wr_target_s = target_r[e_idx_s];
    wr_ctr_s    = ctr_r[e_idx_s];
    if (e_valid && e_is_ctrl) begin
      if (e_hit_s) begin
        wr_en_s = 1'b1;
        if (e_taken) begin
          wr_ctr_s    = ctr_inc(ctr_r[e_idx_s]);
          wr_target_s = e_jumppc;  // refresh target, covers jalr retargeting
        end else begin
          wr_ctr_s    = ctr_dec(ctr_r[e_idx_s]);
        end
      end else if (e_taken) begin
        // Allocate or replace the aliasing entry.
        wr_en_s     = 1'b1;
        wr_target_s = e_jumppc;
        wr_ctr_s    = CTR_ALLOC;
      end else begin
        wr_en_s = 1'b0;
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // BTB storage: flop arrays written by the training decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= '0;
        target_r[i] <= '0;
        ctr_r[i]    <= CTR_RESET;
      end
    end else if (wr_en_s) begin
      valid_r[e_idx_s]  <= 1'b1;
      tag_r[e_idx_s]    <= wr_tag_s;
      target_r[e_idx_s] <= wr_target_s;
      ctr_r[e_idx_s]    <= wr_ctr_s;
    end
  end

  assign redirect_s = e_valid && e_fail_predict;

  // Fetch PC register: redirect beats stall, stall beats prediction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          pc_r <= RESET_PC;
    else if (redirect_s) pc_r <= e_nextpc;
    else if (stall)      pc_r <= pc_r;
    else                 pc_r <= pred_pc_s;
  end

  assign pc           = pc_r;
  assign pc_predicted = pred_pc_s;
  assign pred_taken   = pred_taken_s;

endmodule

// File: tb/tb_f_branch_predict.sv
module tb_f_branch_predict;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, e_valid, e_is_ctrl, e_taken, e_fail_predict;
  logic [12:0] e_pc, e_jumppc, e_nextpc;
  logic [12:0] pc, pc_predicted;
  logic        pred_taken;

  int total = 0;
  int bad   = 0;

  // Reference model: BTB as plain integer tables, counters as 0..3 integers.
  int m_valid [64];
  int m_tag   [64];
  int m_tgt   [64];
  int m_ctr   [64];
  int m_pc;

  f_branch_predict dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .e_valid(e_valid),
    .e_is_ctrl(e_is_ctrl), .e_taken(e_taken), .e_pc(e_pc),
    .e_jumppc(e_jumppc), .e_nextpc(e_nextpc), .e_fail_predict(e_fail_predict),
    .pc(pc), .pc_predicted(pc_predicted), .pred_taken(pred_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_pc = 0;
  endtask

  task automatic m_predict(input int p, output int pred, output int tk);
    int i, t;
    i    = p % 64;
    t    = p / 64;
    tk   = (m_valid[i] != 0 && m_tag[i] == t && m_ctr[i] >= 2) ? 1 : 0;
    pred = tk ? m_tgt[i] : (p + 1) % 8192;
  endtask

  // One clock: drive at negedge, compare against model, apply model at posedge.
  task automatic do_cycle(input bit st, input bit ev, input bit ct, input bit tk,
                          input bit fp, input int epc, input int ejp, input int enp);
    int p, t, np, i, tg;
    @(negedge clk);
    stall = st; e_valid = ev; e_is_ctrl = ct; e_taken = tk; e_fail_predict = fp;
    e_pc = 13'(epc); e_jumppc = 13'(ejp); e_nextpc = 13'(enp);
    #1;
    m_predict(m_pc, p, t);
    chk("pc", 32'(pc), 32'(m_pc));
    chk("pc_predicted", 32'(pc_predicted), 32'(p));
    chk("pred_taken", 32'(pred_taken), 32'(t));
    np = (ev && fp) ? enp : (st ? m_pc : p);
    @(posedge clk);
    if (ev && ct) begin
      i  = epc % 64;
      tg = epc / 64;
      if (m_valid[i] != 0 && m_tag[i] == tg) begin
        if (tk) begin
          m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = ejp;
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (tk) begin
        m_valid[i] = 1; m_tag[i] = tg; m_tgt[i] = ejp; m_ctr[i] = 2;
      end
    end
    m_pc = np;
    #1;
  endtask

  task automatic idle();
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic redirect(input int tgt);
    do_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, tgt);
  endtask

  task automatic train(input int epc, input bit tk, input int ejp);
    do_cycle(1'b1, 1'b1, 1'b1, tk, 1'b0, epc, ejp, 0);
  endtask

  task automatic chk_now(input string nm, input int epc, input int epred, input int etk);
    chk({nm, "_pc"}, 32'(pc), 32'(epc));
    chk({nm, "_pred"}, 32'(pc_predicted), 32'(epred));
    chk({nm, "_taken"}, 32'(pred_taken), 32'(etk));
  endtask

  function automatic int pick_pc();
    int k;
    k = $urandom_range(0, 3);
    if (k == 0) return $urandom_range(0, 8191);
    return ($urandom_range(0, 3) * 64) + $urandom_range(0, 7);
  endfunction

  initial begin
    rst_n = 1'b0; stall = 1'b0; e_valid = 1'b0; e_is_ctrl = 1'b0; e_taken = 1'b0;
    e_fail_predict = 1'b0; e_pc = 13'h0000; e_jumppc = 13'h0000; e_nextpc = 13'h0000;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_now("reset", 0, 1, 0);
    rst_n = 1'b1;

    // Free-running fetch after reset.
    idle(); chk_now("seq1", 1, 2, 0);
    idle(); chk_now("seq2", 2, 3, 0);
    idle(); chk_now("seq3", 3, 4, 0);

    // Allocate and predict.
    train(13'h005, 1'b1, 13'h020);
    redirect(13'h005);
    chk_now("alloc_hit", 13'h005, 13'h020, 1);
    idle();
    chk("alloc_follow", 32'(pc), 32'h020);

    // Counter saturation at 11 and at 00.
    repeat (4) train(13'h005, 1'b1, 13'h020);
    train(13'h005, 1'b0, 13'h000);
    redirect(13'h005);
    chk_now("sat_hi", 13'h005, 13'h020, 1);
    train(13'h005, 1'b0, 13'h000);
    redirect(13'h005);
    chk_now("weak_nt", 13'h005, 13'h006, 0);
    repeat (3) train(13'h005, 1'b0, 13'h000);
    train(13'h005, 1'b1, 13'h020);
    redirect(13'h005);
    chk_now("sat_lo", 13'h005, 13'h006, 0);

    // Redirect beats stall; stall alone holds.
    redirect(13'h100);
    chk("redir_stall", 32'(pc), 32'h100);
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    chk("stall_hold", 32'(pc), 32'h100);

    // Non-control with fail_predict: redirect only, no training.
    do_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 13'h007, 13'h055, 13'h007);
    chk_now("nonctrl", 13'h007, 13'h008, 0);

    // Alias / replace on the same index.
    train(13'h005, 1'b1, 13'h020);
    train(13'h045, 1'b1, 13'h080);
    redirect(13'h005);
    chk_now("alias_old", 13'h005, 13'h006, 0);
    redirect(13'h045);
    chk_now("alias_new", 13'h045, 13'h080, 1);

    // PC wrap.
    redirect(13'h1FFF);
    chk_now("wrap_pre", 13'h1FFF, 13'h0000, 0);
    idle();
    chk("wrap", 32'(pc), 32'h0000);

    // Same-cycle update sees old contents; new ones visible next time.
    redirect(13'h003);
    chk_now("rw_old", 13'h003, 13'h004, 0);
    do_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 13'h003, 13'h050, 0);
    chk("rw_follow", 32'(pc), 32'h004);
    redirect(13'h003);
    chk_now("rw_new", 13'h003, 13'h050, 1);

    // Randomized traffic, with occasional mid-cycle reset.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        e_valid = 1'b1; e_is_ctrl = 1'b1; e_taken = 1'b1; e_fail_predict = 1'b1;
        e_pc = 13'(pick_pc()); e_jumppc = 13'(pick_pc()); e_nextpc = 13'(pick_pc());
        #2;
        rst_n = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        chk_now("mid_reset", 0, 1, 0);
        rst_n = 1'b1;
      end else begin
        do_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 4) == 0, pick_pc(), pick_pc(), pick_pc());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/f_branch_predict.md
Name: f_branch_predict

Overview:
- Fetch-stage PC generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters.
- Holds the architectural fetch PC (13-bit word address) and produces pc_predicted, which travels down the pipeline to the execute-stage PC calculator.
- Consumes that stage's resolution outputs (nextpc, jumppc, taken flag, fail_predict) to redirect fetch and train the BTB.

Parameters:
- PC_W, 13, PC width in words.
- IDX_W, 6, BTB index bits (2^IDX_W entries); tag width = PC_W-IDX_W.
- RESET_PC, 13'h0000, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold fetch PC this cycle.
- e_valid  in  1  execute stage holds a valid resolved instruction.
- e_is_ctrl  in  1  that instruction is branch/jal/jalr.
- e_taken  in  1  resolved taken (branch condition met or jump).
- e_pc  in  PC_W  PC of the resolved instruction.
- e_jumppc  in  PC_W  computed target of the resolved instruction.
- e_nextpc  in  PC_W  architecturally correct next PC.
- e_fail_predict  in  1  misprediction flag from execute.
- pc  out  PC_W  current fetch PC (registered).
- pc_predicted  out  PC_W  predicted next PC for the instruction at pc.
- pred_taken  out  1  prediction used the BTB target.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC.
  - All BTB valid bits = 0; all counters = 2'b01 (weakly not-taken).
  - Tags and targets = 0.
  - Outputs recompute combinationally, so after reset pc_predicted=RESET_PC+1 and pred_taken=0.
  - Reset asserted mid-operation discards any pending update or redirect.
- Lookup (combinational, same cycle as pc):
  - idx = pc[IDX_W-1:0], tag = pc[PC_W-1:IDX_W].
  - hit = valid[idx] & (tag_mem[idx]==tag).
  - pred_taken = hit & ctr[idx][1].
  - pc_predicted = pred_taken ? target[idx] : pc+1, modulo 2^PC_W (13'h1FFF+1 = 0).
- Next-PC select, at the clock edge, in priority order:
  1. e_valid & e_fail_predict -> pc <= e_nextpc. The redirect overrides stall.
  2. stall -> pc holds.
  3. Otherwise pc <= pc_predicted.
- Training at the clock edge, only when e_valid & e_is_ctrl; index and tag are taken from e_pc:
  - Entry hit & e_taken: ctr saturating increment (11 stays 11); target <= e_jumppc, which covers jalr retargeting.
  - Entry hit & !e_taken: ctr saturating decrement (00 stays 00); target unchanged.
  - Entry miss & e_taken: allocate/replace. valid=1, tag written, target=e_jumppc, ctr=2'b10.
  - Entry miss & !e_taken: no change.
  - stall does not block training.
- Read/write ordering:
  - A lookup in the same cycle as an update to the same index sees the old contents.
  - The new contents are visible from the next cycle.
- Non-control instructions (e_is_ctrl=0) never modify the BTB, even if e_fail_predict=1; e_nextpc redirect still applies.
- No internal pipeline state beyond pc and the BTB arrays. Latency from update to prediction is 1 cycle.
- Storage: flop arrays, 2^IDX_W × (1 + tag + PC_W + 2) bits. No SRAM macro.

Test Plan:
- Reset: hold rst_n=0, then release; stall=0, e_valid=0 -> pc sequence 0,1,2,3; pred_taken=0 throughout.
- Allocate and predict:
  - Train e_pc=0x005, e_is_ctrl=1, e_taken=1, e_jumppc=0x020 -> entry 5 valid, ctr=10.
  - When pc=0x005 -> pc_predicted=0x020, pred_taken=1, next pc=0x020.
- Counter saturation:
  - Four taken updates at 0x005 -> ctr=11.
  - Two not-taken updates -> ctr=01; then pc=0x005 predicts 0x006, pred_taken=0.
  - Three further not-taken updates -> ctr stays 00.
- Redirect priority: stall=1 with e_valid=1, e_fail_predict=1, e_nextpc=0x100 -> pc=0x100 next cycle; with stall=1 and no redirect, pc holds.
- Alias/replace: train 0x005 taken->0x020, then 0x045 (same idx, different tag) taken->0x080 -> lookup at 0x005 misses (pc_predicted=0x006); lookup at 0x045 gives 0x080.
- Wrap and same-cycle update:
  - pc=0x1FFF with no hit -> next pc=0x0000.
  - Update idx 3 while pc=0x003 -> that cycle uses old prediction; next occurrence of pc=0x003 uses the new one.
